fpu_frac_iter: RTL and testbench



---
 rtl/fpu_frac_iter_pkg.sv | 8 +
 rtl/fpu_frac_iter_if.sv | 20 ++
 rtl/fpu_frac_iter_div_step.sv | 13 +
 rtl/fpu_frac_iter.sv | 129 ++++++++++++
 tb/tb_fpu_frac_iter.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/fpu_frac_iter_pkg.sv
// Shared constants and FSM encoding for the iterative fraction mul/div stage.
package fpu_iter_pkg;
  localparam int         MUL_ITER   = 24;
  localparam int         DIV_ITER   = 26;
  localparam logic [2:0] FPU_OP_DIV = 3'b011;

  typedef enum logic [1:0] {IDLE, MUL, DIV} iter_state_t;
endpackage

// File: rtl/fpu_frac_iter_if.sv
// Request/result bundle between pre-norm, the fraction iterator and post-norm.
interface fpu_frac_iter_if #(parameter int SIDE_W = 16);
  logic              start;
  logic [2:0]        fpu_op;
  logic [23:0]       fracta;
  logic [23:0]       fractb;
  logic [SIDE_W-1:0] side_in;
  logic              busy;
  logic              done;
  logic [47:0]       prod;
  logic [25:0]       quo;
  logic              rem_nz;
  logic              div_by_zero;
  logic [SIDE_W-1:0] side_out;

  modport master (output start, fpu_op, fracta, fractb, side_in,
                  input  busy, done, prod, quo, rem_nz, div_by_zero, side_out);
  modport slave  (input  start, fpu_op, fracta, fractb, side_in,
                  output busy, done, prod, quo, rem_nz, div_by_zero, side_out);
endinterface

// File: rtl/fpu_frac_iter_div_step.sv
// One restoring-division step: subtract the divisor if it fits.
module frac_div_step (
  input  logic [24:0] r_i,
  input  logic [23:0] d_i,
  output logic [24:0] r_o,
  output logic        q_o
);
  // Compare and conditionally subtract; the caller handles the shift.
  always_comb begin
    q_o = (r_i >= {1'b0, d_i});
    r_o = q_o ? (r_i - {1'b0, d_i}) : r_i;
  end
endmodule

// File: rtl/fpu_frac_iter.sv
// Iterative fraction multiply (shift-add) / divide (restoring) with sideband.
module fpu_frac_iter
  import fpu_iter_pkg::*;
#(
  parameter int SIDE_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  fpu_frac_iter_if.slave  bus
);
  iter_state_t       state_q;
  logic [4:0]        cnt_q;
  logic [24:0]       a_q;
  logic [23:0]       b_q, m_q, d_q;
  logic [24:0]       r_q;
  logic [24:0]       qacc_q;
  logic              dbz_q, anz_q;
  logic [SIDE_W-1:0] side_q;
  logic              busy_q, done_q, rem_nz_q, dbz_out_q;
  logic [47:0]       prod_q;
  logic [25:0]       quo_q;
  logic [SIDE_W-1:0] side_out_q;

  logic [24:0] a_sum, a_d;
  logic [23:0] b_d;
  logic [24:0] r_step;
  logic        q_bit;
  logic        last;

  // Shift-add multiply step: conditional add, then shift {A,B} right by one.
  always_comb begin
    a_sum = b_q[0] ? ({1'b0, a_q[23:0]} + {1'b0, m_q}) : a_q;
    a_d   = {1'b0, a_sum[24:1]};
    b_d   = {a_sum[0], b_q[23:1]};
  end

  frac_div_step u_div_step (
    .r_i (r_q),
    .d_i (d_q),
    .r_o (r_step),
    .q_o (q_bit)
  );

  assign last = (cnt_q == 5'd1);

  // Control FSM plus operand/result registers; results only move on the final edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      m_q        <= '0;
      d_q        <= '0;
      r_q        <= '0;
      qacc_q     <= '0;
      dbz_q      <= 1'b0;
      anz_q      <= 1'b0;
      side_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      prod_q     <= '0;
      quo_q      <= '0;
      rem_nz_q   <= 1'b0;
      dbz_out_q  <= 1'b0;
      side_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          m_q    <= bus.fracta;
          b_q    <= bus.fractb;
          a_q    <= '0;
          r_q    <= {1'b0, bus.fracta};
          d_q    <= bus.fractb;
          qacc_q <= '0;
          // Zero divisor: the datapath shifts the dividend out of R, so
          // the sticky flag comes from the dividend captured here.
          dbz_q  <= (bus.fractb == 24'd0);
          anz_q  <= (bus.fracta != 24'd0);
          side_q <= bus.side_in;
          busy_q <= 1'b1;
          if (bus.fpu_op == FPU_OP_DIV) begin
            state_q <= DIV;
            cnt_q   <= 5'(DIV_ITER);
          end else begin
            state_q <= MUL;
            cnt_q   <= 5'(MUL_ITER);
          end
        end
        MUL: begin
          a_q   <= a_d;
          b_q   <= b_d;
          cnt_q <= cnt_q - 5'd1;
          if (last) begin
            prod_q     <= {a_d[23:0], b_d};
            side_out_q <= side_q;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        DIV: begin
          qacc_q <= {qacc_q[23:0], q_bit};
          r_q    <= r_step << 1;
          cnt_q  <= cnt_q - 5'd1;
          if (last) begin
            quo_q      <= dbz_q ? '1 : {qacc_q, q_bit};
            rem_nz_q   <= dbz_q ? anz_q : (r_step != 25'd0);
            dbz_out_q  <= dbz_q;
            side_out_q <= side_q;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.prod        = prod_q;
  assign bus.quo         = quo_q;
  assign bus.rem_nz      = rem_nz_q;
  assign bus.div_by_zero = dbz_out_q;
  assign bus.side_out    = side_out_q;
endmodule

// File: tb/tb_fpu_frac_iter.sv
// Randomised + directed bench for fpu_frac_iter against an arithmetic model.
module tb_fpu_frac_iter;
  import fpu_iter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_frac_iter_if #(.SIDE_W(16)) bus ();
  fpu_frac_iter #(.SIDE_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  logic [47:0] m_prod = '0;
  logic [25:0] m_quo  = '0;
  logic        m_rnz  = 1'b0;
  logic        m_dbz  = 1'b0;
  logic [15:0] m_side = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer multiply / divide on the accepted operands.
  task automatic model(input logic [2:0] op, input logic [23:0] a, input logic [23:0] b,
                       input logic [15:0] s);
    longint unsigned num;
    m_side = s;
    if (op == 3'b011) begin
      if (b == 24'd0) begin
        m_quo = '1; m_rnz = (a != 24'd0); m_dbz = 1'b1;
      end else begin
        num   = longint'(a) << 25;
        m_quo = 26'(num / longint'(b));
        m_rnz = (num % longint'(b)) != 0;
        m_dbz = 1'b0;
      end
    end else begin
      m_prod = 48'(longint'(a) * longint'(b));
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".prod"}, 64'(bus.prod), 64'(m_prod));
    chk({tag, ".quo"},  64'(bus.quo),  64'(m_quo));
    chk({tag, ".rnz"},  64'(bus.rem_nz), 64'(m_rnz));
    chk({tag, ".dbz"},  64'(bus.div_by_zero), 64'(m_dbz));
    chk({tag, ".side"}, 64'(bus.side_out), 64'(m_side));
  endtask

  // Called #1 after a posedge with the DUT idle; returns #1 after the accept edge.
  task automatic start_op(input logic [2:0] op, input logic [23:0] a, input logic [23:0] b,
                          input logic [15:0] s);
    bus.fpu_op = op; bus.fracta = a; bus.fractb = b; bus.side_in = s;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
    model(op, a, b, s);
  endtask

  task automatic wait_done(input int n, input string tag);
    int cnt = 0;
    bit seen = 0;
    while (!seen && cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
      if (bus.done) seen = 1;
    end
    chk({tag, ".latency"}, 64'(cnt), 64'(n));
    chk({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
    check_outs(tag);
  endtask

  initial begin
    int dones, lat;
    logic [2:0]  op;
    logic [23:0] a, b;
    bus.start = 1'b0; bus.fpu_op = '0; bus.fracta = '0; bus.fractb = '0; bus.side_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    check_outs("rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    start_op(3'b000, 24'h800000, 24'h800000, 16'hA5A5); wait_done(24, "mul_half");
    start_op(3'b001, 24'hFFFFFF, 24'hFFFFFF, 16'h1234); wait_done(24, "mul_max");
    chk("mul_max.value", 64'(bus.prod), 64'h0000_FFFF_FE00_0001);
    start_op(3'b011, 24'hC00000, 24'h800000, 16'h0F0F); wait_done(26, "div_b2b");
    chk("div_b2b.value", 64'(bus.quo), 64'h3000000);
    start_op(3'b011, 24'h800000, 24'hC00000, 16'h7777); wait_done(26, "div_third");
    chk("div_third.value", 64'(bus.quo), 64'h1555555);
    start_op(3'b011, 24'h800000, 24'h000000, 16'hBEEF); wait_done(26, "div_zero");
    start_op(3'b010, 24'h000000, 24'h123456, 16'h0001); wait_done(24, "mul_zero");
    chk("mul_zero.quo_held", 64'(bus.quo), 64'h3FFFFFF);

    // start pulses during a running multiply must be ignored
    start_op(3'b000, 24'hABCDEF, 24'h987654, 16'h5A5A);
    dones = 0; lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 3 || c == 10) begin
        bus.start = 1'b1; bus.fpu_op = 3'b011; bus.fracta = 24'h111111; bus.fractb = 24'h222222;
        bus.side_in = 16'hDEAD;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        if (dones == 1) lat = c;
      end
    end
    chk("ignore.dones", 64'(dones), 64'd1);
    chk("ignore.latency", 64'(lat), 64'd24);
    check_outs("ignore");

    // Reset in the middle of a divide
    start_op(3'b011, 24'hF00000, 24'h900000, 16'hCAFE);
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    m_prod = '0; m_quo = '0; m_rnz = 1'b0; m_dbz = 1'b0; m_side = '0;
    chk("midrst.busy", 64'(bus.busy), 64'd0);
    chk("midrst.done", 64'(bus.done), 64'd0);
    check_outs("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    dones = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("midrst.no_done", 64'(dones), 64'd0);
    start_op(3'b011, 24'hF00000, 24'h900000, 16'hCAFE); wait_done(26, "after_rst");

    // Randomised operations
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'b011) begin
        a = 24'($urandom);
        b = ($urandom_range(0, 7) == 0) ? 24'd0 : (24'($urandom) | 24'h800000);
        start_op(op, a, b, 16'($urandom)); wait_done(26, "rnd_div");
      end else begin
        a = ($urandom_range(0, 9) == 0) ? 24'd0 : 24'($urandom);
        b = 24'($urandom);
        start_op(op, a, b, 16'($urandom)); wait_done(24, "rnd_mul");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
